// File: rtl/pwm_capture.sv
// PWM capture: measures period, high time and integer duty percent of pwm_in.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic [6:0]       duty,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int NW  = WIDTH + 7;
  localparam int ITW = $clog2(NW + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {ARM, MEASURE} state_t;

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("pwm_capture: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [6:0] trunc_duty(input logic [NW-1:0] q);
    return q[6:0];
  endfunction

  state_t            state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              s, lvl, lvl_d, rise, fall;
  logic [WIDTH-1:0]  cnt_q, hi_lat, den_q, hi_q;
  logic              start, tmo_evt, busy_q, last_it;
  logic [ITW-1:0]    it_q;
  logic [WIDTH:0]    rem_q, rem_nxt;
  logic [NW-1:0]     quo_q, quo_nxt;
  logic [WIDTH+1:0]  shifted, diff;
  logic              qbit;

  // Input synchronizer
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end
  assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic           f_q;
  logic [FCW-1:0] fcnt_q;

  // Glitch filter: level follows s only after FILTER_LEN stable cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q    <= 1'b0;
      fcnt_q <= '0;
    end else if (s != f_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        f_q    <= s;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end
  assign lvl = f_q;
`else
  assign lvl = s;
`endif

  // Edge detect and interval counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_d   <= 1'b0;
      cnt_q   <= '0;
      state_q <= ARM;
    end else begin
      lvl_d   <= lvl;
      cnt_q   <= rise ? WIDTH'(1) : sat_inc(cnt_q);
      state_q <= state_d;
    end
  end
  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    tmo_evt = 1'b0;
    case (state_q)
      ARM: if (rise) state_d = MEASURE;
      MEASURE: begin
        if (rise) begin
          start = ~busy_q;
        end else if (cnt_q == CNT_MAX) begin
          tmo_evt = 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = ARM;
    endcase
  end

  // High-time latch; a rise always opens a fresh high interval
  always_ff @(posedge clk) begin
    if (rise)                              hi_lat <= '0;
    else if (state_q == MEASURE && fall)   hi_lat <= cnt_q;
  end

  // Restoring divider step: rem is always below den, so the top bit of shifted stays 0
  assign shifted = {rem_q, quo_q[NW-1]};
  assign diff    = shifted - {2'b00, den_q};
  assign qbit    = ~diff[WIDTH+1];
  assign rem_nxt = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
  assign quo_nxt = {quo_q[NW-2:0], qbit};
  assign last_it = busy_q && (it_q == ITW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      it_q   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      it_q   <= ITW'(NW);
    end else if (busy_q) begin
      it_q   <= it_q - 1'b1;
      busy_q <= ~last_it;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem_q <= '0;
      quo_q <= NW'(hi_lat) * NW'(100);
      den_q <= cnt_q;
      hi_q  <= hi_lat;
    end else if (busy_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  // Result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      period    <= '0;
      high_time <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (last_it) begin
        period    <= den_q;
        high_time <= hi_q;
        duty      <= trunc_duty(quo_nxt);
        valid     <= 1'b1;
        timeout   <= 1'b0;
      end else if (tmo_evt) begin
        period    <= '0;
        high_time <= '0;
        duty      <= lvl ? 7'd100 : 7'd0;
        valid     <= 1'b1;
        timeout   <= 1'b1;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table-driven waveforms, random periods and corner sequences
// checked against an edge-timing reference model.
module tb_pwm_capture;

  localparam int W = 12;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FLT = 4;
`else
  localparam int FLT = 0;
`endif
  localparam int LAT = 2 + W + 8 + FLT;  // drive -> valid, in clock cycles
  localparam int DIV = W + 8;            // min rise spacing for an accepted sample

  logic         clk = 1'b0;
  logic         rst;
  logic         pwm_in;
  logic [W-1:0] period, high_time;
  logic [6:0]   duty;
  logic         valid, timeout, busy;

  pwm_capture dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .period(period), .high_time(high_time),
    .duty(duty), .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int per; int hi; int duty; int tmo; int cyc;} rec_t;
  typedef struct {int p; int h; int n; int d;} vec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   runs_q[$];
  int   cyc = 0;
  int   busy_run = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Model state
  bit armed;
  int prev_rc, prev_fall, prev_p, prev_tab, last_acc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      busy_run <= 0;
    end else begin
      if (valid) got_q.push_back('{int'(period), int'(high_time), int'(duty), int'(timeout), cyc});
      if (busy) busy_run <= busy_run + 1;
      else if (busy_run != 0) begin
        runs_q.push_back(busy_run);
        busy_run <= 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    armed = 0; prev_rc = 0; prev_fall = -1; prev_p = -1; prev_tab = -1; last_acc = -100000;
  endtask

  // A rise closes the previous period; accepted only if the divider is free.
  task automatic on_rise(input int rc);
    int per, hi, d;
    if (armed) begin
      per = rc - prev_rc;
      hi  = (prev_fall < 0) ? 0 : prev_fall - prev_rc;
      d   = (per == prev_p && prev_tab >= 0) ? prev_tab : (hi * 100) / per;
      if (rc - last_acc >= DIV) begin
        exp_q.push_back('{per, hi, d, 0, rc + LAT});
        last_acc = rc;
      end
    end
    armed = 1; prev_rc = rc; prev_fall = -1;
  endtask

  task automatic do_period(input int p, input int h, input int d);
    @(negedge clk); pwm_in = 1'b1; on_rise(cyc);
    prev_p = p; prev_tab = d;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0; prev_fall = cyc;
    repeat (p - h - 1) @(negedge clk);
  endtask

  task automatic hold_high(input int n);
    @(negedge clk); pwm_in = 1'b1; on_rise(cyc);
    exp_q.push_back('{0, 0, 100, 1, -1});
    armed = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_low(input int n);
    pwm_in = 1'b0;
    exp_q.push_back('{0, 0, 0, 1, -1});
    armed = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_seg(input string name);
    repeat (40) @(negedge clk);
    chk($sformatf("%s.count", name), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s[%0d].period", name, i), got_q[i].per, exp_q[i].per);
      chk($sformatf("%s[%0d].high", name, i), got_q[i].hi, exp_q[i].hi);
      chk($sformatf("%s[%0d].duty", name, i), got_q[i].duty, exp_q[i].duty);
      chk($sformatf("%s[%0d].timeout", name, i), got_q[i].tmo, exp_q[i].tmo);
      if (exp_q[i].cyc >= 0)
        chk($sformatf("%s[%0d].cycle", name, i), got_q[i].cyc, exp_q[i].cyc);
    end
    foreach (runs_q[i]) chk($sformatf("%s.busy_len", name), runs_q[i], W + 7);
    exp_q.delete(); got_q.delete(); runs_q.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".period"}, int'(period), 0);
    chk({name, ".high"}, int'(high_time), 0);
    chk({name, ".duty"}, int'(duty), 0);
    chk({name, ".valid"}, int'(valid), 0);
    chk({name, ".timeout"}, int'(timeout), 0);
    chk({name, ".busy"}, int'(busy), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{200, 50, 3, 25};
    vecs[1] = '{100, 37, 3, 37};
    vecs[2] = '{300, 299, 3, 99};
    vecs[3] = '{1000, 1, 2, 0};
    vecs[4] = '{64, 32, 3, 50};
    vecs[5] = '{4000, 3999, 2, 99};
    vecs[6] = '{150, 149, 3, 99};
    vecs[7] = '{30, 10, 3, 33};

    rst = 1'b1; pwm_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Constant low input from reset never arms
    repeat (200) @(negedge clk);
    chk("idle.timeout", int'(timeout), 0);
    check_seg("idle");

    foreach (vecs[k]) begin
      for (int j = 0; j < vecs[k].n; j++) do_period(vecs[k].p, vecs[k].h, vecs[k].d);
      check_seg($sformatf("vec%0d", k));
    end

    hold_high(5000);
    chk("hold_high.timeout_level", int'(timeout), 1);
    check_seg("hold_high");
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    for (int j = 0; j < 3; j++) do_period(120, 30, 25);
    chk("recover.timeout_level", int'(timeout), 0);
    hold_low(5000);
    check_seg("hold_low");

    // Periods shorter than the divide: every other sample is reported
    for (int j = 0; j < 10; j++) do_period(10, 3, 30);
    check_seg("overlap");

    // Reset during a division aborts it
    do_period(100, 37, 37);
    do_period(100, 37, 37);
    @(negedge clk); pwm_in = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("mid_div_reset");
    repeat (2) @(negedge clk);
    pwm_in = 1'b0; rst = 1'b0;
    model_reset();
    for (int j = 0; j < 3; j++) do_period(100, 37, 37);
    check_seg("after_reset");

    for (int j = 0; j < 25; j++) begin
      int p, h;
      p = int'($urandom_range(400, 12));
      h = int'($urandom_range(p - 1, 1));
      do_period(p, h, -1);
    end
    check_seg("random");

    // 2-cycle glitches inside a 100/40 waveform
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); pwm_in = 1'b1;
`ifdef PWM_CAPTURE_FILTER_EN
      on_rise(cyc); prev_p = 100; prev_tab = 40;
`endif
      repeat (10) @(negedge clk); pwm_in = 1'b0;
      repeat (2) @(negedge clk);  pwm_in = 1'b1;
      repeat (28) @(negedge clk); pwm_in = 1'b0; prev_fall = cyc;
      repeat (30) @(negedge clk); pwm_in = 1'b1;
      repeat (2) @(negedge clk);  pwm_in = 1'b0;
      repeat (27) @(negedge clk);
    end
`ifdef PWM_CAPTURE_FILTER_EN
    check_seg("glitch");
`else
    repeat (40) @(negedge clk);
    begin
      int bad;
      bad = 0;
      foreach (got_q[i]) if (got_q[i].per != 100) bad = 1;
      chk("glitch.unfiltered_disturbed", bad, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
